// File: rtl/lcd_hd44780_responder.sv
// Display-side model of an HD44780 character LCD on the 8-bit parallel bus.
// Optional read-back path (busy/AC and DDRAM reads) is enabled by defining LCD_RESP_READ_EN.
module lcd_hd44780_responder #(
    parameter int CMD_CYCLES   = 1850,
    parameter int CLEAR_CYCLES = 76500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    input  logic [4:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       init_done,
    output logic       busy_viol,
    output logic       addr_err
`ifdef LCD_RESP_READ_EN
    ,
    output logic [7:0] rd_data
`endif
);

    localparam int MAX_CYCLES = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

    logic [7:0]       ddram [32];
    logic             e_q;
    logic [CNT_W-1:0] busy_cnt;
    logic             strobe;
    logic             cell_hit;
    logic [4:0]       cell_idx;
    logic             addr_ok;

    // AC walks 0x00-0x27 then 0x40-0x67, wrapping between the two line ranges.
    function automatic logic [6:0] ac_next(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    always_comb begin
        strobe   = e_q & ~lcd_e;
        cell_hit = (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
        cell_idx = {ac[6], ac[3:0]};
        addr_ok  = (lcd_data[5:0] <= 6'h27);
    end

    assign busy = (busy_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
            e_q       <= 1'b0;
            busy_cnt  <= '0;
            ac        <= 7'h00;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            inc_mode  <= 1'b1;
            init_done <= 1'b0;
            fb_data   <= 8'h20;
            busy_viol <= 1'b0;
            addr_err  <= 1'b0;
`ifdef LCD_RESP_READ_EN
            rd_data   <= 8'h00;
`endif
        end else begin
            e_q       <= lcd_e;
            fb_data   <= ddram[fb_addr];
            busy_viol <= 1'b0;
            addr_err  <= 1'b0;
            if (busy) busy_cnt <= busy_cnt - CNT_W'(1);

            if (strobe && !lcd_rw) begin
                if (busy) begin
                    busy_viol <= 1'b1;
                end else if (lcd_rs) begin
                    if (cell_hit) ddram[cell_idx] <= lcd_data;
                    ac       <= ac_next(ac, inc_mode);
                    busy_cnt <= CMD_LOAD;
                end else begin
                    busy_cnt <= CMD_LOAD;
                    casez (lcd_data)
                        8'b1???????: begin
                            if (addr_ok) begin
                                ac <= lcd_data[6:0];
                            end else begin
                                ac       <= 7'h00;
                                addr_err <= 1'b1;
                            end
                        end
                        8'b01??????: ;
                        8'b001?????: begin
                            if (lcd_data[4] && lcd_data[3]) init_done <= 1'b1;
                        end
                        8'b0001????: begin
                            if (!lcd_data[3]) ac <= ac_next(ac, lcd_data[2]);
                        end
                        8'b00001???: begin
                            disp_on   <= lcd_data[2];
                            cursor_on <= lcd_data[1];
                            blink_on  <= lcd_data[0];
                        end
                        8'b000001??: inc_mode <= lcd_data[1];
                        8'b0000001?: begin
                            ac       <= 7'h00;
                            busy_cnt <= CLEAR_LOAD;
                        end
                        8'b00000001: begin
                            for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
                            ac       <= 7'h00;
                            inc_mode <= 1'b1;
                            busy_cnt <= CLEAR_LOAD;
                        end
                        default: ;
                    endcase
                end
            end

`ifdef LCD_RESP_READ_EN
            // Status reads are always honoured; DDRAM reads respect busy like writes.
            if (strobe && lcd_rw) begin
                if (!lcd_rs) begin
                    rd_data <= {busy, ac};
                end else if (busy) begin
                    busy_viol <= 1'b1;
                end else begin
                    rd_data <= cell_hit ? ddram[cell_idx] : 8'h20;
                    ac      <= ac_next(ac, inc_mode);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder with shortened busy timing;
// framebuffer reads are checked through an expected-value queue.
module tb_lcd_hd44780_responder;

    localparam int CMD_CYC = 20;
    localparam int CLR_CYC = 200;

    logic       clk;
    logic       rst_n;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic [4:0] fb_addr;
    logic [7:0] fb_data;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on;
    logic       cursor_on;
    logic       blink_on;
    logic       inc_mode;
    logic       init_done;
    logic       busy_viol;
    logic       addr_err;
`ifdef LCD_RESP_READ_EN
    logic [7:0] rd_data;
`endif

    lcd_hd44780_responder #(
        .CMD_CYCLES  (CMD_CYC),
        .CLEAR_CYCLES(CLR_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .busy     (busy),
        .ac       (ac),
        .disp_on  (disp_on),
        .cursor_on(cursor_on),
        .blink_on (blink_on),
        .inc_mode (inc_mode),
        .init_done(init_done),
        .busy_viol(busy_viol),
        .addr_err (addr_err)
`ifdef LCD_RESP_READ_EN
        ,
        .rd_data  (rd_data)
`endif
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         viol_cnt = 0;
    int         aerr_cnt = 0;
    logic [7:0] exp_fb [32];
    logic [7:0] exp_q  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy_viol) viol_cnt++;
        if (addr_err)  aerr_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One bus transfer; returns #1 after the edge that latches it.
    task automatic applyStimulus(input logic rs, input logic rw, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_e    = 1'b1;
        @(posedge clk); #1;
        lcd_e = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < CLR_CYC + 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) checkOutput("idle_timeout", busy, 1'b0);
    endtask

    task automatic sendCmd(input logic [7:0] c);
        applyStimulus(1'b0, 1'b0, c);
        waitIdle();
    endtask

    task automatic sendData(input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, d);
        waitIdle();
    endtask

    task automatic blankModel();
        for (int i = 0; i < 32; i++) exp_fb[i] = 8'h20;
    endtask

    // Push expected cell values as addresses are issued, pop when fb_data is due.
    task automatic checkFb(input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            fb_addr = 5'(lo + i);
            exp_q.push_back(exp_fb[lo + i]);
            @(posedge clk); #1;
            checkOutput($sformatf("fb[%0d]", lo + i), fb_data, exp_q.pop_front());
        end
    endtask

    initial begin
        string odo;
        string fuel;
        int    start;
        int    v0;
        int    a0;

        odo      = "ODO: 12345 km";
        fuel     = "FUEL";
        rst_n    = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_e    = 1'b0;
        lcd_data = 8'h00;
        fb_addr  = 5'd0;
        blankModel();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ac", ac, 7'h00);
        checkOutput("rst_inc", inc_mode, 1'b1);
        checkOutput("rst_init", init_done, 1'b0);
        checkOutput("rst_disp", {disp_on, cursor_on, blink_on}, 3'b000);
        checkOutput("rst_fb_data", fb_data, 8'h20);
        checkOutput("rst_pulses", {busy_viol, addr_err}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] init sequence");
        sendCmd(8'h30);
        sendCmd(8'h30);
        sendCmd(8'h30);
        checkOutput("init_after_0x30", init_done, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h38);
        start = cyc;
        waitIdle();
        checkOutput("cmd_busy_len", cyc - start, CMD_CYC);
        checkOutput("init_after_0x38", init_done, 1'b1);
        sendCmd(8'h08);
        checkOutput("disp_off", disp_on, 1'b0);
        sendCmd(8'h01);
        sendCmd(8'h06);
        sendCmd(8'h0C);
        checkOutput("init_flags", {init_done, disp_on, cursor_on, blink_on, inc_mode}, 5'b11001);
        checkFb(0, 32);

        $display("[TB] same-cycle read/write");
        fb_addr = 5'd1;
        sendCmd(8'h81);
        applyStimulus(1'b1, 1'b0, 8'h51);
        checkOutput("rw_same_old", fb_data, 8'h20);
        @(posedge clk); #1;
        checkOutput("rw_same_new", fb_data, 8'h51);
        waitIdle();

        $display("[TB] line 1 and line 2 text");
        sendCmd(8'h80);
        for (int i = 0; i < odo.len(); i++) begin
            sendData(odo[i]);
            exp_fb[i] = odo[i];
        end
        checkOutput("ac_after_odo", ac, 7'h0D);
        checkFb(0, 16);
        sendCmd(8'hC0);
        for (int i = 0; i < fuel.len(); i++) begin
            sendData(fuel[i]);
            exp_fb[16 + i] = fuel[i];
        end
        checkOutput("ac_after_fuel", ac, 7'h44);
        checkFb(16, 4);

        $display("[TB] line wrap and invalid address");
        sendCmd(8'hA7);
        checkOutput("ac_0x27", ac, 7'h27);
        sendData(8'h41);
        checkOutput("ac_wrap_0x40", ac, 7'h40);
        sendData(8'h42);
        exp_fb[16] = 8'h42;
        checkOutput("ac_0x41", ac, 7'h41);
        checkFb(0, 32);
        a0 = aerr_cnt;
        applyStimulus(1'b0, 1'b0, 8'hA8);
        checkOutput("addr_err_pulse", addr_err, 1'b1);
        checkOutput("ac_bad_addr", ac, 7'h00);
        @(posedge clk); #1;
        checkOutput("addr_err_drop", addr_err, 1'b0);
        waitIdle();
        checkOutput("addr_err_count", aerr_cnt - a0, 1);

        $display("[TB] decrement mode and cursor shifts");
        sendCmd(8'h04);
        checkOutput("inc_mode_off", inc_mode, 1'b0);
        sendCmd(8'h80);
        sendData(8'h58);
        exp_fb[0] = 8'h58;
        checkOutput("ac_dec_wrap", ac, 7'h67);
        checkFb(0, 1);
        sendCmd(8'h14);
        checkOutput("shift_right_wrap", ac, 7'h00);
        sendCmd(8'h10);
        checkOutput("shift_left_wrap", ac, 7'h67);
        sendCmd(8'h18);
        checkOutput("display_shift_noop", ac, 7'h67);
        sendCmd(8'h0F);
        checkOutput("disp_all_on", {disp_on, cursor_on, blink_on}, 3'b111);
        sendCmd(8'h06);
        checkOutput("inc_mode_on", inc_mode, 1'b1);

        $display("[TB] clear with busy violation");
        v0 = viol_cnt;
        applyStimulus(1'b0, 1'b0, 8'h01);
        start = cyc;
        repeat (100) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 8'h5A);
        checkOutput("busy_viol_pulse", busy_viol, 1'b1);
        waitIdle();
        checkOutput("clear_busy_len", cyc - start, CLR_CYC);
        checkOutput("busy_viol_count", viol_cnt - v0, 1);
        checkOutput("ac_after_clear", ac, 7'h00);
        blankModel();
        checkFb(0, 32);

        $display("[TB] return home");
        sendCmd(8'h80);
        sendData(8'h5A);
        sendData(8'h5B);
        exp_fb[0] = 8'h5A;
        exp_fb[1] = 8'h5B;
        applyStimulus(1'b0, 1'b0, 8'h02);
        start = cyc;
        checkOutput("home_ac", ac, 7'h00);
        waitIdle();
        checkOutput("home_busy_len", cyc - start, CLR_CYC);
        checkFb(0, 2);

        $display("[TB] reset during clear");
        sendCmd(8'h0C);
        applyStimulus(1'b0, 1'b0, 8'h01);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_disp", disp_on, 1'b0);
        checkOutput("midrst_fb_data", fb_data, 8'h20);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postrst_busy", busy, 1'b0);
        blankModel();
        checkFb(0, 32);

`ifdef LCD_RESP_READ_EN
        $display("[TB] read-back");
        sendCmd(8'h85);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("rd_status", rd_data, 8'h05);
        sendCmd(8'h80);
        sendData(8'h4B);
        sendCmd(8'h80);
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("rd_ddram", rd_data, 8'h4B);
        checkOutput("rd_ac_step", ac, 7'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Synthesizable HD44780-compatible character-display responder: the display end of the 8-bit parallel LCD bus (rs/rw/e/data).
- Decodes commands and data writes, maintains a 2x16 visible DDRAM image, address counter, entry/display modes and busy timing.
- Exposes a framebuffer read port for on-chip mirroring (debug 7-seg/VGA) and for checking the LCD driver in simulation.

Parameters:
- CMD_CYCLES, 1850, busy duration in clk cycles for all commands except clear/home (37 us at 50 MHz).
- CLEAR_CYCLES, 76500, busy duration for clear display and return home (1.53 ms).

Ports:
- clk  in  1  system clock, same domain as the LCD driver.
- rst_n  in  1  asynchronous active-low reset.
- lcd_rs  in  1  register select; 0 = command, 1 = data.
- lcd_rw  in  1  0 = write; 1 = read (see Optional Feature).
- lcd_e  in  1  enable strobe; a transfer is latched on its falling edge.
- lcd_data  in  8  bus data.
- fb_addr  in  5  framebuffer read index; 0-15 = line 1 col 0-15, 16-31 = line 2 col 0-15.
- fb_data  out  8  DDRAM byte at fb_addr, registered, 1-cycle latency.
- busy  out  1  busy flag.
- ac  out  7  current DDRAM address counter.
- disp_on, cursor_on, blink_on  out  1 each  display control bits.
- inc_mode  out  1  entry mode I/D bit.
- init_done  out  1  set by the first function set with DL=1 and N=1 (0x38-0x3B, 0x3C-0x3F).
- busy_viol  out  1  one-cycle pulse: a transfer strobed while busy=1.
- addr_err  out  1  one-cycle pulse: set-DDRAM-address to an invalid address.

Behaviour:
- Reset values: DDRAM all 0x20, ac=0, busy=0, disp/cursor/blink=0, inc_mode=1, init_done=0, fb_data=0x20, pulses=0, busy counter=0.
- e_q registers lcd_e each cycle. A strobe is lcd_e=0 and e_q=1. rs/rw/data are sampled in that same cycle.
- Strobe while busy=1: the transfer is dropped, busy_viol pulses, and the busy counter continues.
- Strobe with rw=0 and busy=0 is accepted. busy rises on the next cycle and stays high for exactly CMD_CYCLES or CLEAR_CYCLES cycles.
- Command decode (rs=0), highest set bit wins:
  - 0x80-0xFF: set DDRAM address. Valid addresses are 0x00-0x27 and 0x40-0x67; ac takes the value. Any other address sets ac=0 and pulses addr_err.
  - 0x40-0x7F: set CGRAM address; accepted, busy asserted, no other effect.
  - 0x20-0x3F: function set; updates init_done per the rule above. 0x30 repeats do not set it.
  - 0x10-0x1F: cursor/display shift. Bit 3=0 moves ac by +1 (bit 2=1) or -1 with wrap; bit 3=1 display shift has no effect.
  - 0x08-0x0F: bit 2 = disp_on, bit 1 = cursor_on, bit 0 = blink_on.
  - 0x04-0x07: inc_mode = bit 1; the S bit is ignored.
  - 0x02-0x03: return home; ac=0, CLEAR_CYCLES busy.
  - 0x01: clear; all 32 cells = 0x20, ac=0, inc_mode=1, CLEAR_CYCLES busy. The fill may be iterative if it completes before busy falls.
  - 0x00: accepted, no effect.
- Data write (rs=1): store to DDRAM if ac is in 0x00-0x0F (index ac) or 0x40-0x4F (index 16+ac-0x40). Otherwise discard. Then step ac.
- ac stepping:
  - Increment: 0x27 goes to 0x40 and 0x67 goes to 0x00.
  - Decrement: 0x00 goes to 0x67 and 0x40 goes to 0x27.
- fb_addr read vs. write to the same cell in the same cycle: fb_data shows the old value, then the new one a cycle later.
- rst_n asserted mid-busy or mid-clear: immediate return to reset values, with no partial state retained.

Optional Feature:
- Macro: LCD_RESP_READ_EN.
- Enabled, additional output rd_data (out, 8):
  - On a strobe with rw=1 and rs=0, rd_data={busy,ac} is latched; this read is always accepted, including while busy.
  - With rw=1 and rs=1 while not busy, rd_data = the DDRAM byte at ac (0x20 if ac is outside the visible window), then ac steps.
  - rd_data resets to 0.
- Disabled: rw=1 strobes are ignored. No busy_viol, no state change, no rd_data port.

Test Plan:
- Reset release, then sequence 0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C with gaps ≥ CLEAR_CYCLES -> init_done=1, disp_on=1, cursor_on=0, inc_mode=1, all fb cells 0x20.
- 0x80, then data "ODO: 12345 km" -> fb 0..12 match the ASCII, ac=0x0D; then 0xC0 plus "FUEL" -> fb 16..19 = 0x46,0x55,0x45,0x4C.
- 0xA7 then data 0x41, 0x42 -> 0x41 discarded, ac wraps to 0x40, fb[16]=0x42; 0x28 as address (0xA8) -> addr_err pulse, ac=0.
- 0x04 then 0x80 and data 0x58 -> ac=0x67 after write, fb[0]=0x58.
- 0x01 followed by data strobe 100 cycles later -> busy_viol pulse, data dropped; busy high exactly 76500 cycles.
- rst_n low during a clear's busy window -> busy=0 and DDRAM 0x20 immediately; with LCD_RESP_READ_EN, a rw=1/rs=0 read after 0x85 gives rd_data=0x05.
